// File: rtl/dmem_lsu.sv
// Byte/half/word data memory with req/ack handshake and LATENCY wait states.
// Optional macro DMEM_BOUNDS_EN flags addresses beyond DEPTH*4 bytes as errors.
module dmem_lsu #(
   parameter int DEPTH     = 64,
   parameter int LATENCY   = 1,
   parameter     INIT_FILE = "mem.txt"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sign_ext,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wd,
   output logic [31:0] o_rd,
   output logic        o_busy,
   output logic        o_ack,
   output logic        o_err
);

   localparam int         AW     = $clog2(DEPTH);
   localparam logic [2:0] LAT_M1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rd, r_pend_rd;
   logic        r_err, r_pend_err, r_ack, r_busy;

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [31:0]   w_word, w_ld, w_result, w_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [3:0]    w_be;
   logic          w_oor, w_misalign, w_err, w_accept, w_mem_we;

   assign w_idx  = i_addr[AW+1:2];
   assign w_lane = i_addr[1:0];
   assign w_word = r_mem[w_idx];

`ifdef DMEM_BOUNDS_EN
   assign w_oor = |i_addr[31:AW+2];
`else
   logic w_unused_hi;
   assign w_unused_hi = ^i_addr[31:AW+2];
   assign w_oor       = 1'b0;
`endif

   assign w_misalign = (i_size == 2'b11)
                     | ((i_size == 2'b01) & i_addr[0])
                     | ((i_size == 2'b10) & (|i_addr[1:0]));
   assign w_err      = w_misalign | w_oor;
   assign w_accept   = (r_state == S_IDLE) & i_req;
   assign w_mem_we   = w_accept & i_we & ~w_err & ~reset;

   assign w_byte = 8'(w_word >> {w_lane, 3'b000});
   assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_ld = '0;
      case (i_size)
         2'b00:   w_ld = {{24{i_sign_ext & w_byte[7]}}, w_byte};
         2'b01:   w_ld = {{16{i_sign_ext & w_half[15]}}, w_half};
         2'b10:   w_ld = w_word;
         default: w_ld = '0;
      endcase
   end

   assign w_result = (i_we | w_err) ? '0 : w_ld;

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = i_wd;
      case (i_size)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_wd[7:0]}};
         end
         2'b01: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wd[15:0]}};
         end
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // NOTE: the storage array has no reset; contents survive reset and are not cleared.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd       <= '0;
         r_err      <= 1'b0;
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
         r_pend_rd  <= '0;
         r_pend_err <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_busy     <= 1'b1;
                  r_pend_rd  <= w_result;
                  r_pend_err <= w_err;
                  if (LATENCY == 0) begin
                     r_state <= S_RESP;
                     r_ack   <= 1'b1;
                     r_rd    <= w_result;
                     r_err   <= w_err;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= LAT_M1;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state <= S_RESP;
                  r_ack   <= 1'b1;
                  r_rd    <= r_pend_rd;
                  r_err   <= r_pend_err;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_RESP: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rd   = r_rd;
   assign o_err  = r_err;
   assign o_ack  = r_ack;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, LATENCY=3 handshake
// sequences, reset abort, and randomized accesses against a byte-array model.
module tb_dmem_lsu;

   logic clk, reset;

   logic        req, we, sx;
   logic [1:0]  sz;
   logic [31:0] addr, wd, rd;
   logic        busy, ack, err;

   logic        req3, we3, sx3;
   logic [1:0]  sz3;
   logic [31:0] addr3, wd3, rd3;
   logic        busy3, ack3, err3;

   int total = 0;
   int bad   = 0;

   logic [7:0] mb [256];

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   dmem_lsu #(.DEPTH(64), .LATENCY(1), .INIT_FILE("")) u_l1 (
      .clk(clk), .reset(reset), .i_req(req), .i_we(we), .i_size(sz),
      .i_sign_ext(sx), .i_addr(addr), .i_wd(wd), .o_rd(rd), .o_busy(busy),
      .o_ack(ack), .o_err(err)
   );

   dmem_lsu #(.DEPTH(64), .LATENCY(3), .INIT_FILE("")) u_l3 (
      .clk(clk), .reset(reset), .i_req(req3), .i_we(we3), .i_size(sz3),
      .i_sign_ext(sx3), .i_addr(addr3), .i_wd(wd3), .o_rd(rd3), .o_busy(busy3),
      .o_ack(ack3), .o_err(err3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: little-endian byte array of DEPTH*4 bytes; access width 1<<size bytes.
   task automatic model_access(input logic w, input logic [1:0] s, input logic x,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] r, output logic e);
      int base, n;
      logic [31:0] v;
      logic oor;
      base = int'(a % 256);
      n    = 1 << s;
      oor  = 1'b0;
`ifdef DMEM_BOUNDS_EN
      oor = (a >= 256);
`endif
      e = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) || oor;
      r = '0;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
            if (x && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            r = v;
         end
      end
   endtask

   // One complete LATENCY=1 transaction; checks ack timing, busy, result, and hold.
   task automatic do_access(input logic w, input logic [1:0] s, input logic x,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_err, input string tag);
      int ack_n;
      logic busy_ok;
      logic [31:0] got_rd;
      logic got_err;
      @(negedge clk);
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      we = w; sz = s; sx = x; addr = a; wd = d; req = 1'b1;
      ack_n = -1;
      busy_ok = 1'b1;
      got_rd = '0;
      got_err = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (!busy) busy_ok = 1'b0;
         if (ack) begin
            ack_n = n;
            got_rd = rd;
            got_err = err;
            break;
         end
      end
      req = 1'b0;
      check({tag, " ack latency"}, 32'(ack_n), 32'd1);
      check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " rd"}, got_rd, exp_rd);
      check({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
      @(posedge clk);
      #1;
      check({tag, " rd hold"}, rd, exp_rd);
      check({tag, " ack pulse"}, {31'd0, ack}, 32'd0);
   endtask

   task automatic run_model(input logic w, input logic [1:0] s, input logic x,
                            input logic [31:0] a, input logic [31:0] d, input string tag);
      logic [31:0] er;
      logic ee;
      model_access(w, s, x, a, d, er, ee);
      do_access(w, s, x, a, d, er, ee, tag);
   endtask

   initial begin : main
      logic [31:0] er, a, d;
      logic ee;
      int acks, first, last, ack_e;
      logic [31:0] rd_at_ack;

      reset = 1'b1;
      req = 0; we = 0; sz = 0; sx = 0; addr = 0; wd = 0;
      req3 = 0; we3 = 0; sz3 = 0; sx3 = 0; addr3 = 0; wd3 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset rd", rd, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset ack", {31'd0, ack}, 32'd0);
      check("reset err", {31'd0, err}, 32'd0);
      check("reset busy l3", {31'd0, busy3}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 64; i++) run_model(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init");

      vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13,  32'h12345680, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0});
      vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12,  32'hABCD1234, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'h00001234, 1'b0});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1});
      vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h12,  32'h55555555, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0});
      vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h12,  32'h0,        32'h00000034, 1'b0});
      vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0,   32'hCAFEF00D, 32'h0,        1'b0});
`ifdef DMEM_BOUNDS_EN
      vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1});
`else
      vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 1'b0});
`endif

      foreach (vecs[i]) begin
         model_access(vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr, vecs[i].wd, er, ee);
         do_access(vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr, vecs[i].wd,
                   vecs[i].rd, vecs[i].err, $sformatf("vec%0d", i));
      end

      // LATENCY=3 with req held: one ack per request, 5 cycles apart.
      @(negedge clk);
      we3 = 1'b1; sz3 = 2'd2; sx3 = 1'b0; addr3 = 32'h0; wd3 = 32'h11223344; req3 = 1'b1;
      acks = 0; first = -1; last = -1;
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk);
         #1;
         if (ack3) begin
            if (first < 0) first = e;
            last = e;
            acks++;
         end
      end
      req3 = 1'b0;
      check("l3 held ack count", 32'(acks), 32'd3);
      check("l3 first ack cycle", 32'(first), 32'd4);
      check("l3 ack spacing", 32'(last - first), 32'd10);

      // LATENCY=3 load with a stray req pulse while busy: exactly one ack.
      @(negedge clk);
      we3 = 1'b0; req3 = 1'b1;
      @(posedge clk);
      #1;
      req3 = 1'b0;
      acks = 0; ack_e = -1; rd_at_ack = '0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         if (ack3) begin
            acks++;
            ack_e = e;
            rd_at_ack = rd3;
         end
         req3 = (e == 1);
      end
      req3 = 1'b0;
      check("l3 pulse ack count", 32'(acks), 32'd1);
      check("l3 pulse ack cycle", 32'(ack_e), 32'd3);
      check("l3 load rd", rd_at_ack, 32'h11223344);

      // Reset during the WAIT of a load aborts it and clears outputs asynchronously.
      run_model(1'b1, 2'd2, 1'b0, 32'h20, 32'h600DCAFE, "rst pre store");
      run_model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "rst pre load");
      @(negedge clk);
      we = 1'b0; sz = 2'd2; sx = 1'b0; addr = 32'h20; req = 1'b1;
      @(posedge clk);
      #1;
      check("rst busy accepted", {31'd0, busy}, 32'd1);
      req = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("rst async busy", {31'd0, busy}, 32'd0);
      check("rst async rd", rd, 32'd0);
      check("rst async ack", {31'd0, ack}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      acks = 0;
      for (int e = 0; e < 5; e++) begin
         @(posedge clk);
         #1;
         if (ack) acks++;
      end
      check("rst no ack", 32'(acks), 32'd0);

      // A store interrupted after its acceptance edge stays committed.
      @(negedge clk);
      we = 1'b1; sz = 2'd2; addr = 32'h24; wd = 32'h0BADF00D; req = 1'b1;
      model_access(1'b1, 2'd2, 1'b0, 32'h24, 32'h0BADF00D, er, ee);
      @(posedge clk);
      #1;
      req = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      do_access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 1'b0, "rst commit");
      do_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h600DCAFE, 1'b0, "rst keep");

      for (int i = 0; i < 250; i++) begin
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
         d = $urandom;
         run_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, d, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
